// File: rtl/l2_pkg.sv
// Shared L2 snoop definitions: bus-op codes, snoop result codes, MESI encodings and default geometry.
package l2_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INDEX_W_DEF = 14;
  localparam int TAG_W_DEF   = 12;
  localparam int WAYS_DEF    = 8;

  localparam logic [2:0] OP_READ       = 3'd1;
  localparam logic [2:0] OP_WRITE      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_RWIM       = 3'd4;

  localparam logic [1:0] RES_NOHIT = 2'b00;
  localparam logic [1:0] RES_HIT   = 2'b01;
  localparam logic [1:0] RES_HITM  = 2'b10;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef struct packed {
    logic       upd;
    logic       wb;
    logic       err;
    logic [1:0] nxt;
  } snp_action_t;

endpackage

// File: rtl/l2_snoop_responder_if.sv
// Snoop request/result handshake between the bus-snoop side and the L2 snoop responder.
interface l2_snoop_responder_if
  import l2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              snp_valid;
  logic              snp_ready;
  logic [2:0]        snp_op;
  logic [ADDR_W-1:0] snp_addr;
  logic              res_valid;
  logic [1:0]        res_code;

  modport master (
    output snp_valid, snp_op, snp_addr,
    input  snp_ready, res_valid, res_code
  );

  modport slave (
    input  snp_valid, snp_op, snp_addr,
    output snp_ready, res_valid, res_code
  );
endinterface

// File: rtl/l2_snoop_hit_detect.sv
// Combinational compare of one set: a way hits when its tag matches and its line is not Invalid.
module l2_snoop_hit_detect
  import l2_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int WAYS  = WAYS_DEF,
  localparam int WAY_W = $clog2(WAYS)
)(
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic [WAYS*2-1:0]     mesi,
  output logic                  hit,
  output logic [WAY_W-1:0]      way,
  output logic [1:0]            state,
  output logic                  multi_hit
);

  // Ascending scan keeps the lowest hitting way; any further hit flags a coherence violation.
  always_comb begin
    hit       = 1'b0;
    way       = '0;
    state     = MESI_I;
    multi_hit = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (tags[w*TAG_W +: TAG_W] == tag && mesi[w*2 +: 2] != MESI_I) begin
        if (hit) begin
          multi_hit = 1'b1;
        end else begin
          hit   = 1'b1;
          way   = w[WAY_W-1:0];
          state = mesi[w*2 +: 2];
        end
      end
    end
  end

endmodule

// File: rtl/l2_snoop_responder.sv
// Answers snooped bus ops: looks up the tag/MESI set, reports NOHIT/HIT/HITM, writes back
// Modified data when the transition demands it, then commits the new MESI state.
module l2_snoop_responder
  import l2_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int WAYS    = WAYS_DEF,
  localparam int WAY_W    = $clog2(WAYS),
  localparam int OFFSET_W = ADDR_W - INDEX_W - TAG_W
)(
  input  logic                  clk,
  input  logic                  rst,
  l2_snoop_responder_if.slave   snp,
  output logic                  tag_rd_en,
  output logic [INDEX_W-1:0]    tag_rd_index,
  input  logic [WAYS*TAG_W-1:0] tag_rd_tags,
  input  logic [WAYS*2-1:0]     tag_rd_mesi,
  output logic                  mesi_wr_en,
  output logic [INDEX_W-1:0]    mesi_wr_index,
  output logic [WAY_W-1:0]      mesi_wr_way,
  output logic [1:0]            mesi_wr_state,
  output logic                  wb_req,
  output logic [ADDR_W-1:0]     wb_addr,
  input  logic                  wb_done,
  output logic                  proto_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_DECIDE = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;

  logic [2:0]               state;
  logic [2:0]               op_p0;
  logic [TAG_W+INDEX_W-1:0] line_p0;
  logic [WAY_W-1:0]         way_p1;
  logic [1:0]               nxt_p1;

  logic                     hd_hit;
  logic [WAY_W-1:0]         hd_way;
  logic [1:0]               hd_state;
  logic                     hd_multi;
  snp_action_t              act;

  function automatic snp_action_t decide_action(input logic [2:0] op, input logic hit,
                                                input logic [1:0] st);
    snp_action_t a;
    a     = '0;
    a.nxt = st;
    if (hit) begin
      case (op)
        OP_READ: begin
          if (st == MESI_M) begin
            a.upd = 1'b1; a.wb = 1'b1; a.nxt = MESI_S;
          end else if (st == MESI_E) begin
            a.upd = 1'b1; a.nxt = MESI_S;
          end
        end
        OP_RWIM: begin
          a.upd = 1'b1; a.wb = (st == MESI_M); a.nxt = MESI_I;
        end
        OP_INVALIDATE: begin
          if (st == MESI_S) begin
            a.upd = 1'b1; a.nxt = MESI_I;
          end else begin
            a.err = 1'b1;
          end
        end
        OP_WRITE: a.err = 1'b1;
        default: ;
      endcase
    end
    return a;
  endfunction

  function automatic logic [1:0] result_code(input logic [2:0] op, input logic hit,
                                             input logic [1:0] st);
    logic [1:0] code;
    code = RES_NOHIT;
    case (op)
      OP_READ, OP_WRITE, OP_INVALIDATE, OP_RWIM:
        if (hit) code = (st == MESI_M) ? RES_HITM : RES_HIT;
      default: ;
    endcase
    return code;
  endfunction

  l2_snoop_hit_detect #(.TAG_W(TAG_W), .WAYS(WAYS)) u_hit_detect (
    .tag       (line_p0[TAG_W+INDEX_W-1:INDEX_W]),
    .tags      (tag_rd_tags),
    .mesi      (tag_rd_mesi),
    .hit       (hd_hit),
    .way       (hd_way),
    .state     (hd_state),
    .multi_hit (hd_multi)
  );

  assign act = decide_action(op_p0, hd_hit, hd_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      proto_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (snp.snp_valid) state <= ST_LOOKUP;
        ST_LOOKUP: state <= ST_DECIDE;
        ST_DECIDE: begin
          if (hd_multi || act.err) proto_err <= 1'b1;
          state <= act.wb ? ST_WB : (act.upd ? ST_UPDATE : ST_IDLE);
        end
        ST_WB:     if (wb_done) state <= ST_UPDATE;
        ST_UPDATE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Accept stage: op and line address captured on the handshake
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && snp.snp_valid) begin
      op_p0   <= snp.snp_op;
      line_p0 <= snp.snp_addr[ADDR_W-1:OFFSET_W];
    end
    // Decide stage: target way and new MESI state held for the update
    if (state == ST_DECIDE) begin
      way_p1 <= hd_way;
      nxt_p1 <= act.nxt;
    end
  end

  assign snp.snp_ready  = (state == ST_IDLE);
  assign snp.res_valid  = (state == ST_DECIDE);
  assign snp.res_code   = (state == ST_DECIDE) ? result_code(op_p0, hd_hit, hd_state) : RES_NOHIT;

  assign tag_rd_en      = (state == ST_LOOKUP);
  assign tag_rd_index   = tag_rd_en ? line_p0[INDEX_W-1:0] : '0;

  assign mesi_wr_en     = (state == ST_UPDATE);
  assign mesi_wr_index  = mesi_wr_en ? line_p0[INDEX_W-1:0] : '0;
  assign mesi_wr_way    = mesi_wr_en ? way_p1 : '0;
  assign mesi_wr_state  = mesi_wr_en ? nxt_p1 : MESI_I;

  assign wb_req         = (state == ST_WB);
  assign wb_addr        = wb_req ? {line_p0, {OFFSET_W{1'b0}}} : '0;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Scoreboard bench for l2_snoop_responder: directed snoops against a small tag/MESI array model.
module tb_l2_snoop_responder;
  import l2_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 14;
  localparam int TAG_W    = 12;
  localparam int WAYS     = 8;
  localparam int WAY_W    = 3;
  localparam int OFFSET_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_snoop_responder_if #(.ADDR_W(ADDR_W)) snp();

  logic                  tag_rd_en;
  logic [INDEX_W-1:0]    tag_rd_index;
  logic [WAYS*TAG_W-1:0] tag_rd_tags = '0;
  logic [WAYS*2-1:0]     tag_rd_mesi = '0;
  logic                  mesi_wr_en;
  logic [INDEX_W-1:0]    mesi_wr_index;
  logic [WAY_W-1:0]      mesi_wr_way;
  logic [1:0]            mesi_wr_state;
  logic                  wb_req;
  logic [ADDR_W-1:0]     wb_addr;
  logic                  wb_done;
  logic                  proto_err;

  l2_snoop_responder #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAYS(WAYS)) dut (
    .clk           (clk),
    .rst           (rst),
    .snp           (snp),
    .tag_rd_en     (tag_rd_en),
    .tag_rd_index  (tag_rd_index),
    .tag_rd_tags   (tag_rd_tags),
    .tag_rd_mesi   (tag_rd_mesi),
    .mesi_wr_en    (mesi_wr_en),
    .mesi_wr_index (mesi_wr_index),
    .mesi_wr_way   (mesi_wr_way),
    .mesi_wr_state (mesi_wr_state),
    .wb_req        (wb_req),
    .wb_addr       (wb_addr),
    .wb_done       (wb_done),
    .proto_err     (proto_err)
  );

  typedef struct { logic [1:0] code; int cyc; } res_exp_t;
  typedef struct { logic [INDEX_W-1:0] idx; logic [WAY_W-1:0] way; logic [1:0] st; } wr_exp_t;

  res_exp_t           res_q[$];
  wr_exp_t            wr_q[$];
  logic [ADDR_W-1:0]  wb_q[$];
  logic [INDEX_W-1:0] idx_q[$];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit wb_auto = 1'b1;

  // Tag/MESI array model: sets 0..3 are programmable, every other set reads as all-Invalid.
  logic [WAYS*TAG_W-1:0] mem_tags [0:3];
  logic [WAYS*2-1:0]     mem_mesi [0:3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tag_rd_en) begin
      if (tag_rd_index < 14'd4) begin
        tag_rd_tags <= mem_tags[tag_rd_index[1:0]];
        tag_rd_mesi <= mem_mesi[tag_rd_index[1:0]];
      end else begin
        tag_rd_tags <= '0;
        tag_rd_mesi <= '0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mkaddr(input logic [TAG_W-1:0] tag,
                                               input logic [INDEX_W-1:0] idx,
                                               input logic [OFFSET_W-1:0] off);
    return {tag, idx, off};
  endfunction

  task automatic clear_sets();
    for (int s = 0; s < 4; s++) begin
      mem_tags[s] = '0;
      mem_mesi[s] = '0;
    end
  endtask

  task automatic set_line(input int s, input int w, input logic [TAG_W-1:0] tag, input logic [1:0] st);
    mem_tags[s][w*TAG_W +: TAG_W] = tag;
    mem_mesi[s][w*2 +: 2]         = st;
  endtask

  task automatic exp_wr(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way, input logic [1:0] st);
    wr_exp_t e;
    e.idx = idx; e.way = way; e.st = st;
    wr_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [1:0] code,
                       input int lat, input bit do_wait);
    int k;
    int n;
    res_exp_t r;
    @(negedge clk);
    n = 0;
    while (!snp.snp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", snp.snp_ready, 1);
    k = cyc;
    snp.snp_valid = 1'b1;
    snp.snp_op    = op;
    snp.snp_addr  = a;
    r.code = code;
    r.cyc  = k + 2;
    res_q.push_back(r);
    idx_q.push_back(a[OFFSET_W +: INDEX_W]);
    @(negedge clk);
    snp.snp_valid = 1'b0;
    snp.snp_op    = '0;
    snp.snp_addr  = '0;
    check("ready_busy", snp.snp_ready, 0);
    if (do_wait) begin
      n = 0;
      while (!snp.snp_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("ready_return", snp.snp_ready, 1);
      if (lat > 0) check("ready_latency", cyc - k, lat);
    end
  endtask

  res_exp_t mon_r;
  wr_exp_t  mon_w;

  // Monitor: every DUT-presented transfer is matched against the head of its queue
  initial begin
    forever begin
      @(negedge clk);
      if (tag_rd_en) begin
        if (idx_q.size() == 0) check("unexpected_tag_rd", tag_rd_en, 0);
        else check("tag_rd_index", tag_rd_index, idx_q.pop_front());
      end
      if (snp.res_valid) begin
        if (res_q.size() == 0) check("unexpected_res", snp.res_valid, 0);
        else begin
          mon_r = res_q.pop_front();
          check("res_code", snp.res_code, mon_r.code);
          check("res_cycle", cyc, mon_r.cyc);
        end
      end
      if (mesi_wr_en) begin
        if (wr_q.size() == 0) check("unexpected_mesi_wr", mesi_wr_en, 0);
        else begin
          mon_w = wr_q.pop_front();
          check("mesi_wr_index", mesi_wr_index, mon_w.idx);
          check("mesi_wr_way", mesi_wr_way, mon_w.way);
          check("mesi_wr_state", mesi_wr_state, mon_w.st);
        end
      end
    end
  end

  // Writeback agent: checks the address once per request, answers after a short delay
  bit wb_active = 1'b0;
  int wb_cnt    = 0;
  initial begin
    wb_done = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_req) begin
        if (!wb_active) begin
          wb_active = 1'b1;
          wb_cnt    = 0;
          if (wb_q.size() == 0) check("unexpected_wb", wb_req, 0);
          else check("wb_addr", wb_addr, wb_q.pop_front());
        end else begin
          wb_cnt++;
        end
        wb_done = wb_auto && (wb_cnt >= 2);
      end else begin
        wb_active = 1'b0;
        wb_done   = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    snp.snp_valid = 1'b0;
    snp.snp_op    = '0;
    snp.snp_addr  = '0;
    clear_sets();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_snp_ready", snp.snp_ready, 1);
    check("rst_res_valid", snp.res_valid, 0);
    check("rst_tag_rd_en", tag_rd_en, 0);
    check("rst_mesi_wr_en", mesi_wr_en, 0);
    check("rst_wb_req", wb_req, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_wb_addr", wb_addr, 0);
    rst = 1'b0;

    // READ on Modified: HITM, writeback of line 0x11100000, then way 2 -> S
    set_line(0, 2, 12'h111, MESI_M);
    wb_q.push_back(32'h1110_0000);
    exp_wr(14'd0, 3'd2, MESI_S);
    issue(OP_READ, mkaddr(12'h111, 14'd0, 6'h15), RES_HITM, 0, 1);
    check("read_m_proto_err", proto_err, 0);

    // RWIM on Exclusive: HIT, no writeback, way 2 -> I
    set_line(0, 2, 12'h111, MESI_E);
    exp_wr(14'd0, 3'd2, MESI_I);
    issue(OP_RWIM, mkaddr(12'h111, 14'd0, 6'h00), RES_HIT, 4, 1);

    // Set 1: matching tag only in an Invalid way -> NOHIT
    clear_sets();
    set_line(1, 3, 12'h111, MESI_I);
    set_line(1, 6, 12'h222, MESI_S);
    issue(OP_READ, mkaddr(12'h111, 14'd1, 6'h08), RES_NOHIT, 3, 1);

    // INVALIDATE on Modified: HITM, protocol error, no write
    clear_sets();
    set_line(0, 2, 12'h111, MESI_M);
    issue(OP_INVALIDATE, mkaddr(12'h111, 14'd0, 6'h00), RES_HITM, 3, 1);
    check("inv_m_proto_err", proto_err, 1);
    do_reset();
    check("proto_err_cleared", proto_err, 0);

    // WRITE on Shared: HIT, protocol error, no write
    set_line(0, 2, 12'h111, MESI_S);
    issue(OP_WRITE, mkaddr(12'h111, 14'd0, 6'h3f), RES_HIT, 3, 1);
    check("write_s_proto_err", proto_err, 1);
    do_reset();

    // Same tag valid in ways 1 (E) and 5 (S): lowest way wins, error flagged
    clear_sets();
    set_line(2, 1, 12'h111, MESI_E);
    set_line(2, 5, 12'h111, MESI_S);
    exp_wr(14'd2, 3'd1, MESI_I);
    issue(OP_RWIM, mkaddr(12'h111, 14'd2, 6'h00), RES_HIT, 4, 1);
    check("multi_hit_proto_err", proto_err, 1);
    do_reset();

    // READ on Shared stays Shared: HIT, no write
    clear_sets();
    set_line(3, 0, 12'hABC, MESI_S);
    issue(OP_READ, mkaddr(12'hABC, 14'd3, 6'h00), RES_HIT, 3, 1);
    check("read_s_proto_err", proto_err, 0);

    // Unknown op on a valid line: NOHIT, no write
    issue(3'd6, mkaddr(12'hABC, 14'd3, 6'h00), RES_NOHIT, 3, 1);

    // Tag mismatch on a Modified way: NOHIT
    clear_sets();
    set_line(0, 2, 12'h112, MESI_M);
    issue(OP_READ, mkaddr(12'h111, 14'd0, 6'h00), RES_NOHIT, 3, 1);

    // Reset in the middle of a writeback abandons the op
    clear_sets();
    set_line(0, 7, 12'h111, MESI_M);
    wb_auto = 1'b0;
    wb_q.push_back(32'h1110_0000);
    issue(OP_READ, mkaddr(12'h111, 14'd0, 6'h00), RES_HITM, 0, 0);
    n = 0;
    while (!wb_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wb_req_seen", wb_req, 1);
    repeat (3) @(negedge clk);
    check("wb_req_held", wb_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wb_req", wb_req, 0);
    check("rst_mid_ready", snp.snp_ready, 1);
    check("rst_mid_mesi_wr", mesi_wr_en, 0);
    rst = 1'b0;
    wb_auto = 1'b1;
    repeat (6) @(negedge clk);

    check("res_q_empty", res_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("wb_q_empty", wb_q.size(), 0);
    check("idx_q_empty", idx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
